multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle control path of the RV32I core.
- Sequences each instruction through a Moore FSM: fetch, decode, execute, memory, writeback.
- Drives all datapath enables and muxes for a shared instruction/data memory with a ready handshake.
- Decodes ALU operation, immediate format and branch condition; traps on unsupported opcodes.

Parameters:
- ALU_CTRL_W, 4, width of alucontrol (minimum 4).
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = memory is single-cycle and mem_ready is ignored (treated as 1).
- LUI_EN, 1, 1 = support LUI (0110111); 0 = LUI traps as illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  instruction opcode (from instruction register).
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register enable.
- ir_write  out  1  instruction register and old-PC enable.
- adr_src  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B mux: 00 = rs2, 01 = immediate, 10 = constant 4.
- imm_src  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- alucontrol  out  ALU_CTRL_W  ALU operation code.
- illegal_instr  out  1  sticky trap flag.

Behaviour:
- Reset: async to FETCH. While rst_n = 0, pc_write, ir_write, reg_write, mem_read, mem_write and illegal_instr are 0.
- Default output values are 0; each state lists only the outputs it changes.
- ALU codes (zero-extended to ALU_CTRL_W): ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001.
- aluop is internal: 00 = ADD, 01 = SUB, 10 = decode funct3/funct7.
- Decode under aluop 10:
  - SUB only when op = 0110011 and funct7[5] = 1; otherwise ADD.
  - SRA when funct3 = 101 and funct7[5] = 1.
- FETCH:
  - Outputs: mem_read = 1, adr_src = 0, a = 00, b = 10, aluop 00, result_src = 10.
  - ir_write = pc_update = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: a = 01, b = 01, aluop 00 (branch/jump target). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR; 0010011 -> EXECI.
  - 1100011 -> BRANCH; 1101111 -> JAL.
  - 0110111 -> LUI (if LUI_EN).
  - Any other op -> TRAP.
- MEMADR: a = 10, b = 01, aluop 00. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adr_src = 1, mem_read = 1. Waits for mem_ready, then MEMWB.
- MEMWB: result_src = 01, reg_write = 1, then FETCH.
- MEMWRITE: adr_src = 1, mem_write = 1. Waits for mem_ready, then FETCH. mem_write is held stable during the wait.
- EXECR: a = 10, b = 00, aluop 10, then ALUWB.
- EXECI: a = 10, b = 01, aluop 10, then ALUWB.
- ALUWB: result_src = 00, reg_write = 1, then FETCH.
- BRANCH:
  - a = 10, b = 00, aluop 01, result_src = 00, branch = 1.
  - Taken = zero XOR funct3[0] (BEQ/BNE); any other funct3 -> TRAP.
  - Then FETCH.
- JAL: a = 01, b = 10, aluop 00, result_src = 00, pc_update = 1, then ALUWB.
- LUI: a = 11, b = 01, aluop 00, then ALUWB.
- TRAP: illegal_instr = 1; all enables 0; holds until reset.
- pc_write = pc_update | (branch & taken). This is the only output combinational on the zero input.
- imm_src decodes combinationally from op in every state: loads/OP-IMM I, store S, branch B, JAL J, LUI U, others 000.
- Latency with mem_ready always 1:
  - Branch 3 cycles; R/I-type, store and JAL 4 cycles; load 5 cycles.
  - Each low mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset asserted mid-instruction aborts it; no partial write enable may glitch after rst_n falls.

Decomposition:
- Package mcu_pkg holds:
  - state enum;
  - opcode constants;
  - ALU code constants;
  - mux select constants for result_src, alu_src_a, alu_src_b and imm_src.
- One sub-module: mc_alu_decoder (combinational aluop/funct3/funct7/op -> alucontrol).
- The FSM stays in the top module.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready = 1 -> states FETCH, DECODE, EXECR, ALUWB. reg_write = 1 only in cycle 4; alucontrol = 0000 in EXECR.
- lw with mem_ready low 2 cycles in MEMREAD -> 7 cycles total; mem_read and adr_src = 1 held throughout; reg_write with result_src = 01 exactly once.
- beq with zero = 1 -> pc_write = 1 in BRANCH. Then bne with zero = 1 -> pc_write = 0. alucontrol = 0001 in both.
- sra funct7 = 0100000, funct3 = 101 -> alucontrol = 1000. srai with funct7 = 0100000 -> 1000. addi with imm[11:5] = 0100000 -> 0000.
- op = 1110011, or LUI with LUI_EN = 0 -> TRAP; illegal_instr = 1 sticky, no enables asserted. rst_n pulse -> FETCH, illegal_instr = 0.
- rst_n dropped during MEMWRITE with mem_ready low -> mem_write = 0 immediately; after release, FETCH with mem_read = 1.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, ALU codes and datapath mux selects.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } mcu_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    logic [2:0] sel;
    sel = IMM_I;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      OP_LUI:    sel = IMM_U;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle: the control unit is the master, the datapath
// (instruction fields, flags, memory ready) is the slave.
interface multicycle_control_unit_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  zero;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  ir_write;
  logic                  adr_src;
  logic                  mem_read;
  logic                  mem_write;
  logic                  reg_write;
  logic [1:0]            result_src;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [2:0]            imm_src;
  logic [ALU_CTRL_W-1:0] alucontrol;
  logic                  illegal_instr;

  modport master (
    input  op, funct3, funct7, zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alucontrol, illegal_instr
  );

  modport slave (
    output op, funct3, funct7, zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alucontrol, illegal_instr
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps aluop plus instruction fields to the
// ALU operation code, zero-extended to the configured width.
module mc_alu_decoder
  import mcu_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [1:0]            aluop,
  input  logic [2:0]            funct3,
  input  logic                  funct7_b5,
  input  logic [6:0]            op,
  output logic [ALU_CTRL_W-1:0] alucontrol
);

  logic [3:0] code;

  always_comb begin
    code = ALU_ADD;
    case (aluop)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7[5] on OP-IMM add is immediate data, so only R-type subtracts
          3'b000:  code = (op == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b101:  code = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alucontrol = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with registered per-state outputs and a sticky trap.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_WAIT_EN = 1,
  parameter int LUI_EN      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  mcu_state_e state_q, state_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       reg_write_q, reg_write_d;
  logic       adr_src_q, adr_src_d;
  logic [1:0] result_src_q, result_src_d;
  logic [1:0] src_a_q, src_a_d;
  logic [1:0] src_b_q, src_b_d;
  logic [1:0] aluop_q, aluop_d;
  logic       branch_q, branch_d;
  logic       jal_q, jal_d;
  logic       illegal_q, illegal_d;

  logic mem_ok;
  logic fetch_done;
  logic branch_ok;
  logic funct7_b5;

  assign mem_ok    = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
  assign branch_ok = (bus.funct3[2:1] == 2'b00);
  assign funct7_b5 = bus.funct7[5];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = (LUI_EN != 0) ? S_LUI : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = branch_ok ? S_FETCH : S_TRAP;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      default:    state_d = S_TRAP;
    endcase
  end

  // Outputs are decoded from the state about to be entered so each one is a flop.
  always_comb begin
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    adr_src_d    = 1'b0;
    result_src_d = RES_ALUOUT;
    src_a_d      = SRCA_PC;
    src_b_d      = SRCB_RS2;
    aluop_d      = ALUOP_ADD;
    branch_d     = 1'b0;
    jal_d        = 1'b0;
    illegal_d    = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_read_d   = 1'b1;
        src_b_d      = SRCB_FOUR;
        result_src_d = RES_ALU;
      end
      S_DECODE: begin
        src_a_d = SRCA_OLDPC;
        src_b_d = SRCB_IMM;
      end
      S_MEMADR: begin
        src_a_d = SRCA_RS1;
        src_b_d = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src_d  = 1'b1;
        mem_read_d = 1'b1;
      end
      S_MEMWB: begin
        result_src_d = RES_RDATA;
        reg_write_d  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      S_EXECR: begin
        src_a_d = SRCA_RS1;
        aluop_d = ALUOP_FUNCT;
      end
      S_EXECI: begin
        src_a_d = SRCA_RS1;
        src_b_d = SRCB_IMM;
        aluop_d = ALUOP_FUNCT;
      end
      S_ALUWB:  reg_write_d = 1'b1;
      S_BRANCH: begin
        src_a_d  = SRCA_RS1;
        aluop_d  = ALUOP_SUB;
        branch_d = 1'b1;
      end
      S_JAL: begin
        src_a_d = SRCA_OLDPC;
        src_b_d = SRCB_FOUR;
        jal_d   = 1'b1;
      end
      S_LUI: begin
        src_a_d = SRCA_ZERO;
        src_b_d = SRCB_IMM;
      end
      S_TRAP:   illegal_d = 1'b1;
      default:  illegal_d = 1'b1;
    endcase
  end

  // Reset values mirror FETCH so the muxes are already set when rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      mem_read_q   <= 1'b1;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      adr_src_q    <= 1'b0;
      result_src_q <= RES_ALU;
      src_a_q      <= SRCA_PC;
      src_b_q      <= SRCB_FOUR;
      aluop_q      <= ALUOP_ADD;
      branch_q     <= 1'b0;
      jal_q        <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      adr_src_q    <= adr_src_d;
      result_src_q <= result_src_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      aluop_q      <= aluop_d;
      branch_q     <= branch_d;
      jal_q        <= jal_d;
      illegal_q    <= illegal_d;
    end
  end

  mc_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .aluop      (aluop_q),
    .funct3     (bus.funct3),
    .funct7_b5  (funct7_b5),
    .op         (bus.op),
    .alucontrol (bus.alucontrol)
  );

  // FETCH enables depend on mem_ready, so they are gated by rst_n explicitly.
  assign fetch_done = (state_q == S_FETCH) && mem_ok && rst_n;

  assign bus.ir_write      = fetch_done;
  assign bus.pc_write      = fetch_done | jal_q | (branch_q & branch_ok & (bus.zero ^ bus.funct3[0]));
  assign bus.mem_read      = mem_read_q & rst_n;
  assign bus.mem_write     = mem_write_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.adr_src       = adr_src_q;
  assign bus.result_src    = result_src_q;
  assign bus.alu_src_a     = src_a_q;
  assign bus.alu_src_b     = src_b_q;
  assign bus.imm_src       = imm_src_for(bus.op);
  assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit: walks each
// instruction class cycle by cycle against hand-computed control vectors.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus ();
  multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus2 ();

  multicycle_control_unit #(
    .ALU_CTRL_W  (4),
    .MEM_WAIT_EN (1),
    .LUI_EN      (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Second instance: single-cycle memory, LUI unsupported; shares inputs.
  multicycle_control_unit #(
    .ALU_CTRL_W  (4),
    .MEM_WAIT_EN (0),
    .LUI_EN      (0)
  ) dut_nolui (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus2.op        = bus.op;
  assign bus2.funct3    = bus.funct3;
  assign bus2.funct7    = bus.funct7;
  assign bus2.zero      = bus.zero;
  assign bus2.mem_ready = bus.mem_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input logic rdy);
    @(negedge clk);
    bus.op        = op;
    bus.funct3    = f3;
    bus.funct7    = f7;
    bus.zero      = z;
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic expectVec(input string tag, input logic pcw, input logic irw, input logic adr,
                           input logic mr, input logic mw, input logic rw, input logic [1:0] rs,
                           input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alu);
    checkOutput(tag,
      32'({bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_read, bus.mem_write, bus.reg_write,
           bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alucontrol}),
      32'({pcw, irw, adr, mr, mw, rw, rs, sa, sb, alu}));
  endtask

  task automatic fetchOk(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    applyStimulus(op, f3, f7, 1'b0, 1'b1);
    expectVec({tag, ".fetch"}, 1, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0);
  endtask

  task automatic decodeOk(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [2:0] imm);
    applyStimulus(op, f3, f7, 1'b0, 1'b1);
    expectVec({tag, ".decode"}, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0);
    checkOutput({tag, ".imm"}, 32'(bus.imm_src), 32'(imm));
  endtask

  task automatic runAlu(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [1:0] sb, input logic [3:0] alu);
    fetchOk(tag, op, f3, f7);
    decodeOk(tag, op, f3, f7, 3'b000);
    applyStimulus(op, f3, f7, 1'b0, 1'b1);
    expectVec({tag, ".exec"}, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, sb, alu);
    applyStimulus(op, f3, f7, 1'b0, 1'b1);
    expectVec({tag, ".wb"}, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0);
  endtask

  task automatic runBranch(input string tag, input logic [2:0] f3, input logic z, input logic pcw);
    fetchOk(tag, OP_BRANCH, f3, 7'd0);
    decodeOk(tag, OP_BRANCH, f3, 7'd0, 3'b010);
    applyStimulus(OP_BRANCH, f3, 7'd0, z, 1'b1);
    expectVec({tag, ".br"}, pcw, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.op        = OP_R;
    bus.funct3    = 3'b000;
    bus.funct7    = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset: enables held low even with mem_ready high.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.en", 32'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write, bus.illegal_instr}), 32'h0);
    checkOutput("rst2.en", 32'({bus2.pc_write, bus2.ir_write, bus2.mem_read, bus2.illegal_instr}), 32'h0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    expectVec("rel.fetchwait", 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0);

    // Register and immediate ALU decode.
    runAlu("add",   OP_R,   3'b000, 7'h00, 2'b00, 4'b0000);
    runAlu("sub",   OP_R,   3'b000, 7'h20, 2'b00, 4'b0001);
    runAlu("sra",   OP_R,   3'b101, 7'h20, 2'b00, 4'b1000);
    runAlu("srl",   OP_R,   3'b101, 7'h00, 2'b00, 4'b0111);
    runAlu("sll",   OP_R,   3'b001, 7'h00, 2'b00, 4'b0110);
    runAlu("slt",   OP_R,   3'b010, 7'h00, 2'b00, 4'b0101);
    runAlu("sltu",  OP_R,   3'b011, 7'h00, 2'b00, 4'b1001);
    runAlu("xor",   OP_R,   3'b100, 7'h00, 2'b00, 4'b0100);
    runAlu("or",    OP_R,   3'b110, 7'h00, 2'b00, 4'b0011);
    runAlu("and",   OP_R,   3'b111, 7'h00, 2'b00, 4'b0010);
    runAlu("srai",  OP_IMM, 3'b101, 7'h20, 2'b01, 4'b1000);
    runAlu("addi",  OP_IMM, 3'b000, 7'h20, 2'b01, 4'b0000);
    runAlu("sltiu", OP_IMM, 3'b011, 7'h00, 2'b01, 4'b1001);

    // Load with two wait cycles in MEMREAD: seven cycles total.
    fetchOk("lw", OP_LOAD, 3'b010, 7'd0);
    decodeOk("lw", OP_LOAD, 3'b010, 7'd0, 3'b000);
    applyStimulus(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b1);
    expectVec("lw.memadr", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_LOAD, 3'b010, 7'd0, 1'b0, (i == 2));
      expectVec("lw.memread", 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0);
    end
    applyStimulus(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b1);
    expectVec("lw.memwb", 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'h0);

    // Store with one wait cycle in FETCH.
    applyStimulus(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b0);
    expectVec("sw.fetchwait", 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0);
    fetchOk("sw", OP_STORE, 3'b010, 7'd0);
    decodeOk("sw", OP_STORE, 3'b010, 7'd0, 3'b001);
    applyStimulus(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1);
    expectVec("sw.memadr", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0);
    applyStimulus(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1);
    expectVec("sw.memwrite", 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'h0);

    // Branches: taken = zero XOR funct3[0].
    runBranch("beq.z1", 3'b000, 1'b1, 1'b1);
    runBranch("bne.z1", 3'b001, 1'b1, 1'b0);
    runBranch("bne.z0", 3'b001, 1'b0, 1'b1);
    runBranch("beq.z0", 3'b000, 1'b0, 1'b0);

    // JAL: PC updated in the JAL state, link written in ALUWB.
    fetchOk("jal", OP_JAL, 3'b000, 7'd0);
    decodeOk("jal", OP_JAL, 3'b000, 7'd0, 3'b011);
    applyStimulus(OP_JAL, 3'b000, 7'd0, 1'b0, 1'b1);
    expectVec("jal.jal", 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'h0);
    applyStimulus(OP_JAL, 3'b000, 7'd0, 1'b0, 1'b1);
    expectVec("jal.wb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0);

    // Unsupported opcode traps; trap is sticky with every enable low.
    fetchOk("sys", OP_SYS, 3'b000, 7'd0);
    decodeOk("sys", OP_SYS, 3'b000, 7'd0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_SYS, 3'b000, 7'd0, i[0], 1'b1);
      expectVec("sys.trap", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0);
      checkOutput("sys.illegal", 32'(bus.illegal_instr), 32'h1);
    end

    // Reset clears the trap; the no-LUI instance ignores mem_ready and traps on LUI.
    @(negedge clk);
    rst_n = 1'b0;
    bus.op = OP_LUI;
    bus.mem_ready = 1'b0;
    #1;
    checkOutput("trprst.illegal", 32'(bus.illegal_instr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("trprel.mr", 32'({bus.mem_read, bus.ir_write, bus.illegal_instr}), 32'b100);
    checkOutput("nolui.fetch.irw", 32'(bus2.ir_write), 32'h1);
    applyStimulus(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b0);
    checkOutput("nolui.decode", 32'({bus2.alu_src_a, bus2.alu_src_b, bus2.imm_src}), 32'({2'b01, 2'b01, 3'b100}));
    checkOutput("lui.fetchwait", 32'({bus.mem_read, bus.ir_write}), 32'b10);
    applyStimulus(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b0);
    checkOutput("nolui.trap", 32'({bus2.illegal_instr, bus2.reg_write, bus2.mem_read}), 32'b100);

    // LUI supported on the main instance.
    fetchOk("lui", OP_LUI, 3'b000, 7'd0);
    decodeOk("lui", OP_LUI, 3'b000, 7'd0, 3'b100);
    applyStimulus(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b1);
    expectVec("lui.lui", 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 4'h0);
    applyStimulus(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b1);
    expectVec("lui.wb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0);

    // Unsupported branch funct3 does not write PC and then traps.
    runBranch("blt", 3'b100, 1'b1, 1'b0);
    applyStimulus(OP_BRANCH, 3'b100, 7'd0, 1'b1, 1'b1);
    checkOutput("blt.illegal", 32'(bus.illegal_instr), 32'h1);

    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during a stalled store drops mem_write immediately.
    fetchOk("swab", OP_STORE, 3'b010, 7'd0);
    decodeOk("swab", OP_STORE, 3'b010, 7'd0, 3'b001);
    applyStimulus(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b0);
    expectVec("swab.memadr", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0);
    applyStimulus(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b0);
    expectVec("swab.memwrite", 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'h0);
    @(negedge clk);
    checkOutput("swab.hold", 32'(bus.mem_write), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("swab.rst", 32'({bus.mem_write, bus.mem_read, bus.reg_write, bus.pc_write, bus.ir_write}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expectVec("swab.rel", 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0);

    runAlu("post", OP_R, 3'b000, 7'h20, 2'b00, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
